// File: rtl/lcd_readback_if.sv
// Byte stream plus KS0108 parallel bus of the LCD readback engine.
interface lcd_readback_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [1:0] LCD_cs;
  logic       LCD_di;
  logic       LCD_rw;
  logic       LCD_en;
  logic [7:0] LCD_data_out;
  logic       LCD_data_oe;
  logic [7:0] LCD_data_in;

  modport master (
    output out_data, out_valid, out_last,
    output LCD_cs, LCD_di, LCD_rw, LCD_en, LCD_data_out, LCD_data_oe,
    input  out_ready, LCD_data_in
  );

  modport slave (
    input  out_data, out_valid, out_last,
    input  LCD_cs, LCD_di, LCD_rw, LCD_en, LCD_data_out, LCD_data_oe,
    output out_ready, LCD_data_in
  );
endinterface

// File: rtl/lcd_readback.sv
// Reads the two-chip KS0108 display RAM back and streams it as bytes (page, chip, column order).
// Define LCD_READBACK_BUSY_EN to poll the panel busy flag instead of inserting WAIT_CYC idle cycles.
module lcd_readback #(
  parameter int PAGES        = 8,
  parameter int COLS         = 64,
  parameter int BUSY_TIMEOUT = 255,
  parameter int WAIT_CYC     = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           err,
  lcd_readback_if.master bus
);
`ifdef LCD_READBACK_BUSY_EN
  localparam bit BUSY_MODE = 1'b1;
`else
  localparam bit BUSY_MODE = 1'b0;
`endif
  // One counter serves either the idle wait or the busy-poll count.
  localparam logic [7:0] CNT_LAST  = BUSY_MODE ? 8'(BUSY_TIMEOUT - 1) : 8'(WAIT_CYC - 1);
  localparam logic [2:0] PAGE_LAST = 3'(PAGES - 1);
  localparam logic [5:0] COL_LAST  = 6'(COLS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETPG  = 3'd1;
  localparam logic [2:0] S_SETCOL = 3'd2;
  localparam logic [2:0] S_DUMMY  = 3'd3;
  localparam logic [2:0] S_READ   = 3'd4;
  localparam logic [2:0] S_OWAIT  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [2:0] PH_PRE = 3'd0;
  localparam logic [2:0] PH_PHI = 3'd1;
  localparam logic [2:0] PH_PHO = 3'd2;
  localparam logic [2:0] PH_SU  = 3'd3;
  localparam logic [2:0] PH_HI  = 3'd4;
  localparam logic [2:0] PH_HO  = 3'd5;

  logic [2:0] r_state;
  logic [2:0] r_phase;
  logic [7:0] r_cnt;
  logic [2:0] r_page;
  logic       r_chip;
  logic [5:0] r_col;
  logic [7:0] r_odata;
  logic       r_valid;
  logic       r_last;
  logic       r_err;
`ifdef LCD_READBACK_BUSY_EN
  logic       r_stat;
`endif
  logic       w_acc;
  logic       w_xfer;
  logic       w_poll;
  logic       w_wr;

  assign w_acc  = (r_state == S_SETPG) || (r_state == S_SETCOL) ||
                  (r_state == S_DUMMY) || (r_state == S_READ);
  assign w_xfer = w_acc && ((r_phase == PH_SU) || (r_phase == PH_HI) || (r_phase == PH_HO));
  assign w_poll = BUSY_MODE && w_acc && !w_xfer;
  assign w_wr   = (r_state == S_SETPG) || (r_state == S_SETCOL);

  assign busy          = (r_state != S_IDLE);
  assign err           = r_err;
  assign bus.out_data  = r_odata;
  assign bus.out_valid = r_valid;
  assign bus.out_last  = r_last;

  // Chip stays selected while waiting on the consumer; DONE/IDLE release the bus.
  assign bus.LCD_cs       = (w_acc || (r_state == S_OWAIT)) ? (r_chip ? 2'b10 : 2'b01) : 2'b00;
  assign bus.LCD_di       = w_xfer && !w_wr;
  assign bus.LCD_rw       = (w_xfer && !w_wr) || w_poll;
  assign bus.LCD_en       = w_acc && ((r_phase == PH_HI) || (r_phase == PH_PHI));
  assign bus.LCD_data_oe  = w_xfer && w_wr;
  assign bus.LCD_data_out = !(w_xfer && w_wr)   ? 8'h00 :
                            (r_state == S_SETPG) ? {5'b10111, r_page} : 8'h40;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_phase <= PH_PRE;
      r_cnt   <= '0;
      r_page  <= '0;
      r_chip  <= 1'b0;
      r_col   <= '0;
      r_odata <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
`ifdef LCD_READBACK_BUSY_EN
      r_stat  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_SETPG;
          r_phase <= PH_PRE;
          r_cnt   <= '0;
          r_page  <= '0;
          r_chip  <= 1'b0;
          r_col   <= '0;
          r_err   <= 1'b0;
        end
        S_SETPG, S_SETCOL, S_DUMMY, S_READ: begin
          case (r_phase)
`ifdef LCD_READBACK_BUSY_EN
            PH_PRE: r_phase <= PH_PHI;
            PH_PHI: begin
              r_stat  <= bus.LCD_data_in[7];
              r_phase <= PH_PHO;
            end
            PH_PHO: begin
              if (!r_stat) begin
                r_cnt   <= '0;
                r_phase <= PH_SU;
              end else if (r_cnt == CNT_LAST) begin
                r_err   <= 1'b1;
                r_valid <= 1'b0;
                r_cnt   <= '0;
                r_phase <= PH_PRE;
                r_state <= S_DONE;
              end else begin
                r_cnt   <= r_cnt + 8'd1;
                r_phase <= PH_PRE;
              end
            end
`else
            PH_PRE: begin
              if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_phase <= PH_SU;
              end else begin
                r_cnt   <= r_cnt + 8'd1;
              end
            end
`endif
            PH_SU: r_phase <= PH_HI;
            PH_HI: begin
              r_phase <= PH_HO;
              if (r_state == S_READ) r_odata <= bus.LCD_data_in;
            end
            PH_HO: begin
              r_phase <= PH_PRE;
              case (r_state)
                S_SETPG:  r_state <= S_SETCOL;
                S_SETCOL: r_state <= S_DUMMY;
                S_DUMMY:  r_state <= S_READ;
                default: begin
                  r_state <= S_OWAIT;
                  r_valid <= 1'b1;
                  r_last  <= r_chip && (r_page == PAGE_LAST) && (r_col == COL_LAST);
                end
              endcase
            end
            default: r_phase <= PH_PRE;
          endcase
        end
        // The panel Y counter already advanced on the read, so the next READ needs no re-address.
        S_OWAIT: if (bus.out_ready) begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          if (r_col != COL_LAST) begin
            r_col   <= r_col + 6'd1;
            r_state <= S_READ;
          end else begin
            r_col   <= '0;
            r_state <= S_SETPG;
            if (!r_chip) begin
              r_chip <= 1'b1;
            end else begin
              r_chip <= 1'b0;
              if (r_page == PAGE_LAST) r_state <= S_DONE;
              else r_page <= r_page + 3'd1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_readback.sv
// Bench for lcd_readback: full-size instance and a 1-page/2-column instance, each on a KS0108 panel model.
`timescale 1ns/1ps
module tb_lcd_readback;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic ready0 = 1'b0;
  logic ready1 = 1'b0;
  logic busy0, err0, busy1, err1;
  bit   stuck  [2];
  int   hold_n [2];
  int   n_cmp = 0;
  int   n_bad = 0;

  lcd_readback_if if0 ();
  lcd_readback_if if1 ();
  assign if0.out_ready = ready0;
  assign if1.out_ready = ready1;

  lcd_readback u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .err(err0), .bus(if0)
  );
  lcd_readback #(.PAGES(1), .COLS(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .err(err1), .bus(if1)
  );

  logic [1:0] m_cs   [2];
  logic       m_di   [2];
  logic       m_rw   [2];
  logic       m_en   [2];
  logic       m_oe   [2];
  logic [7:0] m_dout [2];
  logic [7:0] m_din  [2];
  assign m_cs[0]   = if0.LCD_cs;       assign m_cs[1]   = if1.LCD_cs;
  assign m_di[0]   = if0.LCD_di;       assign m_di[1]   = if1.LCD_di;
  assign m_rw[0]   = if0.LCD_rw;       assign m_rw[1]   = if1.LCD_rw;
  assign m_en[0]   = if0.LCD_en;       assign m_en[1]   = if1.LCD_en;
  assign m_oe[0]   = if0.LCD_data_oe;  assign m_oe[1]   = if1.LCD_data_oe;
  assign m_dout[0] = if0.LCD_data_out; assign m_dout[1] = if1.LCD_data_out;
  assign if0.LCD_data_in = m_din[0];
  assign if1.LCD_data_in = m_din[1];

  // Panel model: RAM byte = {chip, page, col[3:0]}; reads return the output latch loaded by the previous read.
  for (genvar g = 0; g < 2; g++) begin : g_m
    logic [2:0] pg [2];
    logic [5:0] y  [2];
    logic [7:0] oreg      = 8'h00;
    logic       after_col = 1'b0;
    logic       sel;
    int n_pg = 0, n_col = 0, n_dum = 0, n_stat = 0, n_run = 0;
    assign sel      = m_cs[g][1];
    assign m_din[g] = (m_rw[g] && m_di[g]) ? oreg : {(stuck[g] || (n_run < hold_n[g])), 7'b0};
    always @(posedge clk) begin
      if (m_en[g]) begin
        if (!m_rw[g] && !m_di[g] && m_oe[g]) begin
          if (m_dout[g][7:3] == 5'b10111) begin
            pg[sel] <= m_dout[g][2:0];
            n_pg    <= n_pg + 1;
          end else if (m_dout[g][7:6] == 2'b01) begin
            y[sel]    <= m_dout[g][5:0];
            n_col     <= n_col + 1;
            after_col <= 1'b1;
          end
          n_run <= 0;
        end else if (m_rw[g] && m_di[g]) begin
          oreg      <= {sel, pg[sel], y[sel][3:0]};
          y[sel]    <= y[sel] + 6'd1;
          if (after_col) n_dum <= n_dum + 1;
          after_col <= 1'b0;
          n_run     <= 0;
        end else if (m_rw[g] && !m_di[g]) begin
          n_stat <= n_stat + 1;
          n_run  <= n_run + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [25:0] outs0();
    return {busy0, err0, if0.out_valid, if0.out_last, if0.out_data, if0.LCD_cs, if0.LCD_di,
            if0.LCD_rw, if0.LCD_en, if0.LCD_data_oe, if0.LCD_data_out};
  endfunction

  task automatic pulse_start(input int which);
    if (which != 0) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    ready1 = 1'b0;
  endtask

  task automatic get_byte(input int which, output logic [7:0] d, output logic l, output bit ok);
    int t = 0;
    while (!(which != 0 ? if1.out_valid : if0.out_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = (which != 0) ? if1.out_valid : if0.out_valid;
    d  = (which != 0) ? if1.out_data  : if0.out_data;
    l  = (which != 0) ? if1.out_last  : if0.out_last;
    if (ok) begin
      if (which != 0) ready1 = 1'b1; else ready0 = 1'b1;
      @(negedge clk);
      ready0 = 1'b0;
      ready1 = 1'b0;
    end
  endtask

  typedef struct {
    string      name;
    int         idx;
    logic [7:0] exp_d;
    logic       exp_l;
  } vec_t;
  vec_t       vt [13];
  logic [7:0] sd [4] = '{8'h00, 8'h01, 8'h80, 8'h81};
  logic [7:0] got_d [1024];
  logic       got_l [1024];

  initial begin
    logic [7:0] d;
    logic       l;
    bit         ok;
    logic [9:0] nn;
    int n_last, bad_stream, stall_bad, s0, t;

    vt[0]  = '{"b0",    0,    8'h00, 1'b0};
    vt[1]  = '{"b5",    5,    8'h05, 1'b0};
    vt[2]  = '{"b6",    6,    8'h06, 1'b0};
    vt[3]  = '{"b15",   15,   8'h0F, 1'b0};
    vt[4]  = '{"b16",   16,   8'h00, 1'b0};
    vt[5]  = '{"b63",   63,   8'h0F, 1'b0};
    vt[6]  = '{"b64",   64,   8'h80, 1'b0};
    vt[7]  = '{"b100",  100,  8'h84, 1'b0};
    vt[8]  = '{"b101",  101,  8'h85, 1'b0};
    vt[9]  = '{"b128",  128,  8'h10, 1'b0};
    vt[10] = '{"b200",  200,  8'h98, 1'b0};
    vt[11] = '{"b1022", 1022, 8'hFE, 1'b0};
    vt[12] = '{"b1023", 1023, 8'hFF, 1'b1};
    for (int i = 0; i < 1024; i++) begin
      got_d[i] = 8'h00;
      got_l[i] = 1'b0;
    end
    hold_n[0] = 0;
    hold_n[1] = 3;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(outs0()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Small instance; out_ready is high together with start in IDLE.
    ready1 = 1'b1;
    pulse_start(1);
    chk("small_busy_on", 32'(busy1), 32'd1);
    for (int i = 0; i < 4; i++) begin
      get_byte(1, d, l, ok);
      if (!ok) begin
        chk("small_wait", 32'(ok), 32'd1);
        break;
      end
      chk($sformatf("small_d%0d", i), 32'(d), 32'(sd[i]));
      chk($sformatf("small_l%0d", i), 32'(l), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("small_busy_done", 32'(busy1), 32'd1);
    @(negedge clk);
    chk("small_busy_off", 32'(busy1), 32'd0);
    chk("small_setpage", g_m[1].n_pg, 32'd2);
    chk("small_setcol", g_m[1].n_col, 32'd2);
    chk("small_dummy", g_m[1].n_dum, 32'd2);

`ifdef LCD_READBACK_BUSY_EN
    stuck[1] = 1'b1;
    s0 = g_m[1].n_stat;
    pulse_start(1);
    t = 0;
    while (busy1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("to_busy_off", 32'(busy1), 32'd0);
    chk("to_err", 32'(err1), 32'd1);
    chk("to_cs", 32'(if1.LCD_cs), 32'd0);
    chk("to_valid", 32'(if1.out_valid), 32'd0);
    chk("to_last", 32'(if1.out_last), 32'd0);
    chk("to_polls", g_m[1].n_stat - s0, 32'd255);
    stuck[1] = 1'b0;
    pulse_start(1);
    chk("err_clear", 32'(err1), 32'd0);
`else
    chk("no_status_polls", g_m[1].n_stat, 32'd0);
    chk("small_err", 32'(err1), 32'd0);
`endif

    // Full-size readback with a consumer stall at byte 5 and a stray start at byte 100.
    pulse_start(0);
    n_last    = 0;
    stall_bad = 0;
    for (int n = 0; n < 1024; n++) begin
      if (n == 100) begin
        pulse_start(0);
        chk("restart_ignored_busy", 32'(busy0), 32'd1);
      end
      if (n == 5) begin
        t = 0;
        while (!if0.out_valid && t < 3000) begin
          @(negedge clk);
          t++;
        end
        d = if0.out_data;
        for (int k = 0; k < 10; k++) begin
          if (!if0.out_valid || if0.out_data !== d || if0.LCD_en !== 1'b0) stall_bad++;
          @(negedge clk);
        end
      end
      get_byte(0, d, l, ok);
      if (!ok) begin
        chk("main_wait", 32'(ok), 32'd1);
        break;
      end
      got_d[n] = d;
      got_l[n] = l;
      if (l) n_last++;
    end
    chk("stall_stable", stall_bad, 32'd0);
    chk("main_busy_done", 32'(busy0), 32'd1);
    @(negedge clk);
    chk("main_busy_off", 32'(busy0), 32'd0);
    chk("main_err", 32'(err0), 32'd0);
    chk("last_count", n_last, 32'd1);
    for (int i = 0; i < 13; i++) begin
      chk({vt[i].name, "_d"}, 32'(got_d[vt[i].idx]), 32'(vt[i].exp_d));
      chk({vt[i].name, "_l"}, 32'(got_l[vt[i].idx]), 32'(vt[i].exp_l));
    end
    bad_stream = 0;
    for (int n = 0; n < 1024; n++) begin
      nn = 10'(n);
      if (got_d[n] !== {nn[6], nn[9:7], nn[3:0]}) bad_stream++;
    end
    chk("stream_order", bad_stream, 32'd0);

    // Reset in the middle of a second readback, then restart from page 0 column 0.
    pulse_start(0);
    for (int n = 0; n < 300; n++) begin
      get_byte(0, d, l, ok);
      if (!ok) begin
        chk("rst_run_wait", 32'(ok), 32'd1);
        break;
      end
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", 32'(outs0()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(0);
    get_byte(0, d, l, ok);
    chk("restart_b0", {23'd0, ok, d}, 32'h100);
    get_byte(0, d, l, ok);
    chk("restart_b1", {23'd0, ok, d}, 32'h101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
